pipe_barrel_shifter: RTL

PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

---
 rtl/pipe_barrel_shifter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_barrel_shifter.sv
// rtl/pipe_barrel_shifter.sv - two-stage pipelined barrel shifter/rotator with ready/valid handshake
// Optional registered zero flag on the result when BSH_ZERO_FLAG_EN is defined.
module pipe_barrel_shifter #(
    parameter int N = 3,
    localparam int W = 1 << N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [N-1:0] amt,
    input  logic [1:0]   op,
    input  logic         s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y
`ifdef BSH_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [N-1:0] s1_amt;
    logic [1:0]   s1_op;
    logic         s1_s;

    logic         s2_adv;
    logic         in_fire;

    // Stage 2 frees up when empty or draining; stage 1 may then refill in the same cycle.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    logic         rot_l;
    logic         rotate;
    logic         fill;
    logic [W-1:0] a_rev;
    logic [W-1:0] pre;
    logic [W-1:0] core;
    logic [W-1:0] core_rev;
    logic [W-1:0] post;
    logic [W-1:0] post_rev;
    logic [W-1:0] result;
    logic [W-1:0] lvl [0:N];

    assign rot_l  = (s1_op == OP_ROL);
    assign rotate = s1_op[1];
    assign fill   = (s1_op == OP_SRA) && s1_a[W-1];

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign a_rev[i]    = s1_a[W-1-i];
        assign core_rev[i] = core[W-1-i];
        assign post_rev[i] = post[W-1-i];
    end

    // Rotate left is done as a right rotate of the bit-reversed operand, reversed back.
    assign pre    = rot_l ? a_rev : s1_a;
    assign lvl[0] = pre;

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [W-1:0] moved;
        assign moved = rotate ? {lvl[k][SH-1:0], lvl[k][W-1:SH]}
                              : {{SH{fill}}, lvl[k][W-1:SH]};
        assign lvl[k+1] = s1_amt[k] ? moved : lvl[k];
    end

    assign core   = lvl[N];
    assign post   = rot_l ? core_rev : core;
    assign result = s1_s ? post_rev : post;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_amt   <= '0;
            s1_op    <= OP_SRL;
            s1_s     <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_fire) begin
                s1_a   <= a;
                s1_amt <= amt;
                s1_op  <= op;
                s1_s   <= s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y <= result;
            end
        end
    end

`ifdef BSH_ZERO_FLAG_EN
    // Registered with y under the same enable so the flag can never disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero <= 1'b1;
        end else if (s2_adv && s1_valid) begin
            zero <= (result == '0);
        end
    end
`endif

endmodule
